ram_arbiter: RTL and testbench
==============================

// Module: ram_arbiter
// PURPOSE
//  Two-requester round-robin arbiter/sequencer for the single-port ram block
//  (10-bit addr, 8-bit bidirectional data bus, rd/wr/cs strobes).
//  - Accepts one read or write command per requester.
//  - Serialises commands onto the RAM pins and drives the shared data bus only during writes.
//  - Returns read data with a one-cycle valid pulse.
//  - Sits between the RAM and two client blocks.
// PARAMETERS
//  AW  10  address width (RAM depth 2**AW)
//  DW  8   data width
// PORTS
//  clk       in     1   clock, all state updates on posedge
//  rst_n     in     1   asynchronous active-low reset
//  req0      in     1   requester 0 command request, held until gnt0 seen
//  we0       in     1   requester 0: 1=write, 0=read
//  addr0     in     AW  requester 0 address
//  wdata0    in     DW  requester 0 write data
//  gnt0      out    1   command 0 accepted (1-cycle pulse)
//  rvalid0   out    1   rdata0 updated (1-cycle pulse)
//  rdata0    out    DW  requester 0 read data, held until next read 0
//  req1/we1/addr1/wdata1/gnt1/rvalid1/rdata1   same for requester 1
//  busy      out    1   high whenever state != IDLE
//  ram_addr  out    AW  RAM address
//  ram_data  inout  DW  RAM data bus; driven only in WR state, else Z
//  ram_cs    out    1   RAM chip select
//  ram_rd    out    1   RAM read strobe
//  ram_wr    out    1   RAM write strobe
// BEHAVIOUR
//  - Reset (async, immediate): state=IDLE; gnt*, rvalid*, ram_cs/rd/wr, busy=0.
//    rdata*=0, ram_addr=0, ram_data=Z. RR pointer last=1, so req0 wins the first tie.
//  - Reset mid-operation aborts the operation: no gnt/rvalid, and RAM contents
//    for the aborted write are undefined.
//  - All RAM-side outputs and gnt/rvalid are registered.
//  - FSM states: IDLE, WR, RD1, RD2.
//    IDLE: no req -> stay. Else winner = only requester, or on tie the one != last.
//      Latch winner addr/we/wdata; last<=winner; gnt_winner<=1 for one cycle.
//      -> WR if we, else RD1.
//    WR: ram_cs=1, ram_wr=1, ram_data=latched wdata; RAM writes at end of cycle. -> IDLE.
//    RD1: ram_cs=1, ram_rd=1; RAM registers the word at end of cycle. -> RD2.
//    RD2: ram_cs=1, ram_rd=1 held; RAM drives ram_data. At end of cycle,
//      rdata_winner<=ram_data and rvalid_winner<=1 (pulse). -> IDLE.
//  - Latency, counted from the IDLE edge that grants:
//    write completes after 1 cycle, throughput 2 cycles/op;
//    rvalid is seen 2 cycles after grant, throughput 3 cycles/op.
//  - Every op returns through IDLE. This mandatory idle cycle gives bus
//    turnaround: ram_data is never driven in the cycle after RD2.
//  - ram_rd and ram_wr are never both high. ram_cs=0 in IDLE.
//  - req/we/addr/wdata are sampled only in IDLE.
//  - Requester protocol: hold the command stable until gnt is high, and may drop
//    or change req at the edge where gnt is seen. A new req in the post-op IDLE
//    cycle is legal.
//  - Fairness: with both req held continuously, grants alternate strictly 0,1,0,1.
//  - Addresses are used unmodified, with no wrap logic; 0 and 2**AW-1 are legal.
// TESTING
//  1 req0 write addr 5 data AA, then req0 read addr 5 -> gnt0 pulses once each;
//    ram_wr high 1 cycle; rvalid0 2 cycles after read grant; rdata0=AA.
//  2 Same edge: req0 write addr 10 data 55, req1 read addr 10 -> req0 granted first;
//    req1 then gets rdata1=55 and rvalid1 pulse.
//  3 req0 and req1 reads held continuously for 6 ops -> gnt sequence 0,1,0,1,0,1;
//    rdata routed to the correct requester.
//  4 Assertions throughout all tests:
//    - ram_rd and ram_wr never both high.
//    - ram_data is Z whenever state != WR.
//    - ram_cs=0 in IDLE.
//    - gnt0 and gnt1 never both high.
//  5 rst_n low during RD2 of a read of addr 5 -> ram_cs/ram_rd drop immediately;
//    no rvalid. After release, read addr 5 -> AA.
//  6 req1 write addr 3FF data 3C, read 3FF and addr 0 -> rdata1=3C;
//    addr 0 returns its previous value.

Source files
------------

// File: rtl/ram_arbiter.sv
// Two-requester round-robin arbiter and sequencer for a single-port RAM.
// Commands are serialised onto registered RAM strobes, and each operation returns through IDLE.
module ram_arbiter #(
  parameter int AW = 10,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          gnt0,
  output logic          rvalid0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt1,
  output logic          rvalid1,
  output logic [DW-1:0] rdata1,
  output logic          busy,
  output logic [AW-1:0] ram_addr,
  inout  wire  [DW-1:0] ram_data,
  output logic          ram_cs,
  output logic          ram_rd,
  output logic          ram_wr
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD1  = 2'd2,
    RD2  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic          last_q, last_d;
  logic          win_q, win_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          drive_q, drive_d;
  logic          cs_q, cs_d;
  logic          rd_q, rd_d;
  logic          wr_q, wr_d;
  logic          gnt0_q, gnt0_d;
  logic          gnt1_q, gnt1_d;
  logic          rvalid0_q, rvalid0_d;
  logic          rvalid1_q, rvalid1_d;
  logic [DW-1:0] rdata0_q, rdata0_d;
  logic [DW-1:0] rdata1_q, rdata1_d;
  logic          busy_q, busy_d;
  logic          win_sel;
  logic          sel_we;

  // Next-state and registered-output logic for the sequencer.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    win_d     = win_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    drive_d   = 1'b0;
    cs_d      = 1'b0;
    rd_d      = 1'b0;
    wr_d      = 1'b0;
    gnt0_d    = 1'b0;
    gnt1_d    = 1'b0;
    rvalid0_d = 1'b0;
    rvalid1_d = 1'b0;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    win_sel   = 1'b0;
    sel_we    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          // On a tie, the requester that did not win last time goes first.
          if (req0 && req1) begin
            win_sel = ~last_q;
          end else begin
            win_sel = req1;
          end
          sel_we  = win_sel ? we1 : we0;
          win_d   = win_sel;
          last_d  = win_sel;
          addr_d  = win_sel ? addr1 : addr0;
          wdata_d = win_sel ? wdata1 : wdata0;
          gnt0_d  = ~win_sel;
          gnt1_d  = win_sel;
          cs_d    = 1'b1;
          if (sel_we) begin
            state_d = WR;
            wr_d    = 1'b1;
            drive_d = 1'b1;
          end else begin
            state_d = RD1;
            rd_d    = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WR: begin
        state_d = IDLE;
      end
      RD1: begin
        state_d = RD2;
        cs_d    = 1'b1;
        rd_d    = 1'b1;
      end
      RD2: begin
        state_d = IDLE;
        if (win_q) begin
          rdata1_d  = ram_data;
          rvalid1_d = 1'b1;
        end else begin
          rdata0_d  = ram_data;
          rvalid0_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      win_q     <= 1'b0;
      addr_q    <= {AW{1'b0}};
      wdata_q   <= {DW{1'b0}};
      drive_q   <= 1'b0;
      cs_q      <= 1'b0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= {DW{1'b0}};
      rdata1_q  <= {DW{1'b0}};
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      win_q     <= win_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      drive_q   <= drive_d;
      cs_q      <= cs_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      gnt0_q    <= gnt0_d;
      gnt1_q    <= gnt1_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
      busy_q    <= busy_d;
    end
  end

  assign ram_data = drive_q ? wdata_q : {DW{1'bz}};
  assign ram_addr = addr_q;
  assign ram_cs   = cs_q;
  assign ram_rd   = rd_q;
  assign ram_wr   = wr_q;
  assign gnt0     = gnt0_q;
  assign gnt1     = gnt1_q;
  assign rvalid0  = rvalid0_q;
  assign rvalid1  = rvalid1_q;
  assign rdata0   = rdata0_q;
  assign rdata1   = rdata1_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: a behavioural single-port RAM on the bus,
// a table of single-requester operations, and directed tie, fairness and reset sequences.
module tb_ram_arbiter;
  localparam int AW = 10;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0, we0, req1, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1, busy;
  logic [DW-1:0] rdata0, rdata1;
  logic [AW-1:0] ram_addr;
  wire  [DW-1:0] ram_data;
  logic          ram_cs, ram_rd, ram_wr;

  always #5 clk = ~clk;

  ram_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .busy(busy), .ram_addr(ram_addr), .ram_data(ram_data),
    .ram_cs(ram_cs), .ram_rd(ram_rd), .ram_wr(ram_wr)
  );

  // RAM model: word registered in the first read cycle, driven in the second.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] ram_dout;
  logic          rd_prev;
  logic          ram_drive;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_prev <= 1'b0;
    else        rd_prev <= ram_cs & ram_rd;
  end

  always @(posedge clk) begin
    if (ram_cs && ram_wr) mem[ram_addr] <= ram_data;
    if (ram_cs && ram_rd) ram_dout <= mem[ram_addr];
  end

  assign ram_drive = ram_cs & ram_rd & rd_prev;
  assign ram_data  = ram_drive ? ram_dout : {DW{1'bz}};

  int vectors = 0;
  int miscompares = 0;
  logic [DW-1:0] exp_rd0, exp_rd1;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endfunction

  // A released bus reads all-Z, or all-0 where the simulator is two-state.
  function automatic logic bus_released();
    return (ram_data === {DW{1'bz}}) || (ram_data === {DW{1'b0}});
  endfunction

  // Bus invariants sampled every cycle outside reset.
  always @(negedge clk) begin
    if (rst_n) begin
      check("rd_wr_exclusive", {31'd0, ram_rd & ram_wr}, 32'd0);
      check("gnt_exclusive", {31'd0, gnt0 & gnt1}, 32'd0);
      if (!busy) check("cs_low_in_idle", {31'd0, ram_cs}, 32'd0);
      if (!ram_wr && !ram_drive) check("bus_released", {31'd0, bus_released()}, 32'd1);
    end
  end

  typedef struct {
    bit            who;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [DW-1:0] exp;
  } vec_t;

  // Issue one command from an idle arbiter (called at a negedge) and follow it to completion.
  task automatic do_op(input bit who, input bit we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [DW-1:0] exp, input string tag);
    int n;
    bit got;
    if (!who) begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; end
    else      begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; end
    n = 0;
    got = 1'b0;
    while (!got && n < 8) begin
      @(negedge clk);
      n++;
      got = who ? gnt1 : gnt0;
    end
    req0 = 1'b0;
    req1 = 1'b0;
    check({tag, "_gnt_latency"}, n, 32'd1);
    check({tag, "_other_gnt"}, {31'd0, who ? gnt0 : gnt1}, 32'd0);
    check({tag, "_ram_addr"}, {22'd0, ram_addr}, {22'd0, a});
    if (we) begin
      check({tag, "_ram_wr"}, {31'd0, ram_wr}, 32'd1);
      check({tag, "_wdata_on_bus"}, {24'd0, ram_data}, {24'd0, d});
      @(negedge clk);
      check({tag, "_wr_one_cycle"}, {31'd0, ram_wr}, 32'd0);
      check({tag, "_gnt_pulse"}, {31'd0, who ? gnt1 : gnt0}, 32'd0);
      check({tag, "_idle_after_wr"}, {31'd0, busy}, 32'd0);
    end else begin
      check({tag, "_ram_rd"}, {31'd0, ram_rd}, 32'd1);
      @(negedge clk);
      check({tag, "_gnt_pulse"}, {31'd0, who ? gnt1 : gnt0}, 32'd0);
      check({tag, "_rvalid_early"}, {31'd0, who ? rvalid1 : rvalid0}, 32'd0);
      @(negedge clk);
      check({tag, "_rvalid"}, {31'd0, who ? rvalid1 : rvalid0}, 32'd1);
      check({tag, "_rdata"}, {24'd0, who ? rdata1 : rdata0}, {24'd0, exp});
      if (who) exp_rd1 = exp;
      else     exp_rd0 = exp;
      check({tag, "_other_rdata_held"}, {24'd0, who ? rdata0 : rdata1},
            {24'd0, who ? exp_rd0 : exp_rd1});
      @(negedge clk);
      check({tag, "_rvalid_pulse"}, {31'd0, who ? rvalid1 : rvalid0}, 32'd0);
    end
  endtask

  vec_t vecs [8];
  int   gwho [6];
  int   gcyc [6];
  int   grants, r0cnt, r1cnt;

  initial begin
    vecs[0] = '{who: 1'b0, we: 1'b1, addr: 10'h005, data: 8'hAA, exp: 8'h00};
    vecs[1] = '{who: 1'b0, we: 1'b0, addr: 10'h005, data: 8'h00, exp: 8'hAA};
    vecs[2] = '{who: 1'b0, we: 1'b1, addr: 10'h000, data: 8'h11, exp: 8'h00};
    vecs[3] = '{who: 1'b1, we: 1'b1, addr: 10'h007, data: 8'h5A, exp: 8'h00};
    vecs[4] = '{who: 1'b0, we: 1'b0, addr: 10'h007, data: 8'h00, exp: 8'h5A};
    vecs[5] = '{who: 1'b1, we: 1'b1, addr: 10'h3FF, data: 8'h3C, exp: 8'h00};
    vecs[6] = '{who: 1'b1, we: 1'b0, addr: 10'h3FF, data: 8'h00, exp: 8'h3C};
    vecs[7] = '{who: 1'b1, we: 1'b0, addr: 10'h000, data: 8'h00, exp: 8'h11};

    rst_n = 1'b0;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    exp_rd0 = 8'h00;
    exp_rd1 = 8'h00;

    repeat (2) @(negedge clk);
    check("rst_gnt", {30'd0, gnt0, gnt1}, 32'd0);
    check("rst_rvalid", {30'd0, rvalid0, rvalid1}, 32'd0);
    check("rst_strobes", {29'd0, ram_cs, ram_rd, ram_wr}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_rdata", {16'd0, rdata0, rdata1}, 32'd0);
    check("rst_ram_addr", {22'd0, ram_addr}, 32'd0);
    check("rst_bus", {31'd0, bus_released()}, 32'd1);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_idle", {31'd0, busy}, 32'd0);

    // Simultaneous write (req0) and read (req1) of the same address: req0 wins the first tie.
    req0 = 1'b1; we0 = 1'b1; addr0 = 10'h00A; wdata0 = 8'h55;
    req1 = 1'b1; we1 = 1'b0; addr1 = 10'h00A;
    @(negedge clk);
    check("tie_gnt0", {30'd0, gnt0, gnt1}, 32'd2);
    check("tie_wr", {31'd0, ram_wr}, 32'd1);
    req0 = 1'b0;
    @(negedge clk);
    check("tie_turnaround", {29'd0, gnt0, gnt1, busy}, 32'd0);
    @(negedge clk);
    check("tie_gnt1", {30'd0, gnt0, gnt1}, 32'd1);
    check("tie_rd", {31'd0, ram_rd}, 32'd1);
    req1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("tie_rvalid1", {30'd0, rvalid0, rvalid1}, 32'd1);
    check("tie_rdata1", {24'd0, rdata1}, 32'h55);
    exp_rd1 = 8'h55;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      do_op(vecs[i].who, vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].exp,
            $sformatf("vec%0d", i));
    end

    // Both requesters hold reads continuously: grants must alternate every three cycles.
    req0 = 1'b1; we0 = 1'b0; addr0 = 10'h005;
    req1 = 1'b1; we1 = 1'b0; addr1 = 10'h00A;
    grants = 0; r0cnt = 0; r1cnt = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if ((gnt0 || gnt1) && grants < 6) begin
        gwho[grants] = gnt1 ? 1 : 0;
        gcyc[grants] = cyc;
        grants++;
        if (grants == 6) begin req0 = 1'b0; req1 = 1'b0; end
      end
      if (rvalid0) begin
        r0cnt++;
        check("rr_rdata0", {24'd0, rdata0}, 32'hAA);
      end
      if (rvalid1) begin
        r1cnt++;
        check("rr_rdata1", {24'd0, rdata1}, 32'h55);
      end
      if (grants == 6 && r0cnt + r1cnt == 6) break;
    end
    req0 = 1'b0; req1 = 1'b0;
    check("rr_grant_count", grants, 32'd6);
    for (int k = 0; k < grants; k++) begin
      check($sformatf("rr_order%0d", k), gwho[k], k % 2);
      check($sformatf("rr_spacing%0d", k), gcyc[k] - gcyc[0], 3 * k);
    end
    check("rr_rvalid0_count", r0cnt, 32'd3);
    check("rr_rvalid1_count", r1cnt, 32'd3);
    exp_rd0 = 8'hAA;
    exp_rd1 = 8'h55;
    @(negedge clk);

    // Reset asserted in the second read cycle aborts the read without a valid pulse.
    req0 = 1'b1; we0 = 1'b0; addr0 = 10'h005;
    @(negedge clk);
    check("abort_gnt0", {31'd0, gnt0}, 32'd1);
    req0 = 1'b0;
    @(negedge clk);
    check("abort_in_rd2", {30'd0, ram_cs, ram_rd}, 32'd3);
    #1 rst_n = 1'b0;
    #1;
    check("abort_strobes", {29'd0, ram_cs, ram_rd, ram_wr}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_bus", {31'd0, bus_released()}, 32'd1);
    check("abort_rdata0", {24'd0, rdata0}, 32'd0);
    repeat (2) begin
      @(negedge clk);
      check("abort_no_rvalid", {30'd0, rvalid0, rvalid1}, 32'd0);
    end
    rst_n = 1'b1;
    exp_rd0 = 8'h00;
    exp_rd1 = 8'h00;
    @(negedge clk);
    check("abort_no_late_rvalid", {30'd0, rvalid0, rvalid1}, 32'd0);
    do_op(1'b0, 1'b0, 10'h005, 8'h00, 8'hAA, "post_abort_read");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
